// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: opcode classes, FSM states and decoded-op encodings for the issue stage
package issue_ctrl_pkg;
  localparam int OPT_W = 7;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef enum logic [1:0] {IS_EMPTY, IS_HELD, IS_JWAIT} is_state_t;
  typedef enum logic [1:0] {CLS_ILL, CLS_RS, CLS_LSB} cls_t;
  typedef enum logic [OPT_W-1:0] {
    OPT_NOP, OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
    OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
    OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU, OPT_SB, OPT_SH, OPT_SW,
    OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
    OPT_SLLI, OPT_SRLI, OPT_SRAI,
    OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR, OPT_SRL, OPT_SRA, OPT_OR, OPT_AND
  } opt_t;
  function automatic cls_t opc_cls(input logic [6:0] op);
    return (op == OPC_LOAD || op == OPC_STORE) ? CLS_LSB :
           (op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_OPIMM, OPC_OP}) ? CLS_RS : CLS_ILL;
  endfunction
endpackage

// File: rtl/issue_ctrl_decoder.sv
// decoder: RV32I instruction word to decoded op, register indices and immediate
module decoder import issue_ctrl_pkg::*; (
  input  logic [31:0]      inst,
  output logic [OPT_W-1:0] opt,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [31:0]      imm
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       alt;
  opt_t       o;
  assign op  = inst[6:0];
  assign f3  = inst[14:12];
  assign alt = inst[30];
  assign rd  = inst[11:7];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign opt = o;
  // immediate by format; shift-immediates carry only the shift amount
  always_comb begin
    imm = {{21{inst[31]}}, inst[30:20]};
    if (op == OPC_LUI || op == OPC_AUIPC) imm = {inst[31:12], 12'b0};
    else if (op == OPC_JAL) imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    else if (op == OPC_BRANCH) imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (op == OPC_STORE) imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
    else if (op == OPC_OPIMM && f3[1:0] == 2'b01) imm = {27'b0, inst[24:20]};
  end
  // operation selection from opcode, funct3 and funct7 bit 30
  always_comb begin
    o = OPT_NOP;
    case (op)
      OPC_LUI:   o = OPT_LUI;
      OPC_AUIPC: o = OPT_AUIPC;
      OPC_JAL:   o = OPT_JAL;
      OPC_JALR:  o = OPT_JALR;
      OPC_BRANCH:
        case (f3)
          3'd0: o = OPT_BEQ;
          3'd1: o = OPT_BNE;
          3'd4: o = OPT_BLT;
          3'd5: o = OPT_BGE;
          3'd6: o = OPT_BLTU;
          3'd7: o = OPT_BGEU;
          default: ;
        endcase
      OPC_LOAD:
        case (f3)
          3'd0: o = OPT_LB;
          3'd1: o = OPT_LH;
          3'd2: o = OPT_LW;
          3'd4: o = OPT_LBU;
          3'd5: o = OPT_LHU;
          default: ;
        endcase
      OPC_STORE:
        case (f3)
          3'd0: o = OPT_SB;
          3'd1: o = OPT_SH;
          3'd2: o = OPT_SW;
          default: ;
        endcase
      OPC_OPIMM:
        case (f3)
          3'd0: o = OPT_ADDI;
          3'd1: o = OPT_SLLI;
          3'd2: o = OPT_SLTI;
          3'd3: o = OPT_SLTIU;
          3'd4: o = OPT_XORI;
          3'd5: o = alt ? OPT_SRAI : OPT_SRLI;
          3'd6: o = OPT_ORI;
          default: o = OPT_ANDI;
        endcase
      OPC_OP:
        case (f3)
          3'd0: o = alt ? OPT_SUB : OPT_ADD;
          3'd1: o = OPT_SLL;
          3'd2: o = OPT_SLT;
          3'd3: o = OPT_SLTU;
          3'd4: o = OPT_XOR;
          3'd5: o = alt ? OPT_SRA : OPT_SRL;
          3'd6: o = OPT_OR;
          default: o = OPT_AND;
        endcase
      default: ;
    endcase
  end
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: single-entry in-order issue stage feeding ROB plus RS or LSB
module issue_ctrl import issue_ctrl_pkg::*; #(
  parameter int ROB_TAG_W = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 iq_valid,
  input  logic [31:0]          iq_inst,
  input  logic [31:0]          iq_pc,
  input  logic                 iq_pred,
  output logic                 iq_pop,
  input  logic                 rob_full,
  input  logic [ROB_TAG_W-1:0] rob_tag,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  input  logic                 rob_flush,
  input  logic                 jalr_done,
  output logic                 rob_issue,
  output logic                 rs_issue,
  output logic                 lsb_issue,
  output logic [OPT_W-1:0]     iss_opt,
  output logic [4:0]           iss_rd,
  output logic [4:0]           iss_rs1,
  output logic [4:0]           iss_rs2,
  output logic [31:0]          iss_imm,
  output logic [31:0]          iss_pc,
  output logic                 iss_pred,
  output logic [ROB_TAG_W-1:0] iss_tag
);
  is_state_t   state;
  logic [31:0] h_inst, h_pc;
  logic        h_pred, h_jalr, tgt_full, go, live;
  cls_t        h_cls, q_cls;
  assign h_cls     = opc_cls(h_inst[6:0]);
  assign q_cls     = opc_cls(iq_inst[6:0]);
  assign h_jalr    = h_inst[6:0] == OPC_JALR;
  assign tgt_full  = h_cls == CLS_LSB ? lsb_full : rs_full;
  assign live      = ~rst_in & rdy_in & ~rob_flush;
  assign go        = live & (state == IS_HELD) & ~rob_full & ~tgt_full;
  assign iq_pop    = live & iq_valid & ((state == IS_EMPTY) | (go & ~h_jalr));
  assign rob_issue = go;
  assign rs_issue  = go & (h_cls == CLS_RS);
  assign lsb_issue = go & (h_cls == CLS_LSB);
  assign iss_pc    = h_pc;
  assign iss_pred  = h_pred;
  assign iss_tag   = rob_tag;
  decoder u_dec (
    .inst(h_inst),
    .opt (iss_opt),
    .rd  (iss_rd),
    .rs1 (iss_rs1),
    .rs2 (iss_rs2),
    .imm (iss_imm)
  );
  // a pop refills the slot (illegal words land in EMPTY and are never issued); a JALR parks in JWAIT
  always_ff @(posedge clk_in) begin
    if (rst_in | rob_flush) begin
      state  <= IS_EMPTY;
      h_inst <= '0;
      h_pc   <= '0;
      h_pred <= 1'b0;
    end else if (iq_pop) begin
      state  <= q_cls == CLS_ILL ? IS_EMPTY : IS_HELD;
      h_inst <= iq_inst;
      h_pc   <= iq_pc;
      h_pred <= iq_pred;
    end else if (go) begin
      state <= h_jalr ? IS_JWAIT : IS_EMPTY;
    end else if (rdy_in & (state == IS_JWAIT) & jalr_done) begin
      state <= IS_EMPTY;
    end
  end
endmodule
